nf_fetch_unit: RTL and testbench

Instruction fetch sequencer placed directly upstream of the CPU core. It takes the core's program-counter output, runs a request/acknowledge read on a variable-latency instruction bus, and latches the returned word. It then presents that word on the core's `instr` input and pulses the core's `cpu_en` for exactly one cycle per fetched instruction. Bus errors and timeouts halt the core with a sticky error flag.

---
 rtl/nf_fetch_unit.sv | 156 +++++++++++++++
 tb/tb_nf_fetch_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nf_fetch_unit.sv
// nf_fetch_unit: instruction fetch sequencer between the core's PC and a
// variable-latency request/acknowledge instruction bus. Each fetched word is
// latched onto instr and announced to the core with a single-cycle cpu_en.
// Bus errors and request timeouts park the block in a sticky HALT state.
//
// Bus handshake: ibus_req is the request-valid. Once raised it stays high,
// with ibus_addr held stable, until the slave ends the transaction by
// asserting ibus_ack (data valid on ibus_rdata in that same cycle) or
// ibus_err. The request is never withdrawn except by reset or by the
// internal timeout. ibus_err wins over a simultaneous ibus_ack.
module nf_fetch_unit #(
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        run,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr,
  output logic        cpu_en,
  output logic [31:0] ibus_addr,
  output logic        ibus_req,
  input  logic        ibus_ack,
  input  logic [31:0] ibus_rdata,
  input  logic        ibus_err,
  output logic        busy,
  output logic        fetch_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_EXEC = 2'd2,
    S_HALT = 2'd3
  } state_t;

  // Timeout limit narrowed to the counter width; a zero limit disables it.
  localparam logic [15:0] LP_TIMEOUT = TIMEOUT[15:0];
  localparam logic        LP_TO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] LP_TO_LAST = LP_TIMEOUT - 16'd1;
  localparam logic [15:0] LP_CNT_MAX = 16'hFFFF;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_cnt;
  logic [31:0] r_instr;
  logic [31:0] r_ibus_addr;

  logic w_in_idle;
  logic w_in_req;
  logic w_launch;
  logic w_bus_err;
  logic w_bus_ack;
  logic w_timeout;

  // Transaction events, all qualified by the registered state.
  assign w_in_idle = (r_state == S_IDLE);
  assign w_in_req  = (r_state == S_REQ);
  assign w_launch  = w_in_idle && run;
  assign w_bus_err = w_in_req && ibus_err;
  assign w_bus_ack = w_in_req && !ibus_err && ibus_ack;
  // Counter value c means this is REQ cycle c+1, so TIMEOUT-1 marks the last
  // cycle in which an acknowledge is still accepted.
  assign w_timeout = w_in_req && !ibus_err && !ibus_ack &&
                     LP_TO_EN && (r_cnt == LP_TO_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_next_state = S_REQ;
        end
      end
      S_REQ: begin
        if (ibus_err) begin
          w_next_state = S_HALT;
        end else if (ibus_ack) begin
          w_next_state = S_EXEC;
        end else if (w_timeout) begin
          w_next_state = S_HALT;
        end
      end
      // The core commits on the closing edge of EXEC; returning to IDLE lets
      // the next launch pick up the updated PC.
      S_EXEC:  w_next_state = S_IDLE;
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Decoded outputs, driven only from the registered state.
  always_comb begin
    ibus_req  = 1'b0;
    busy      = 1'b0;
    cpu_en    = 1'b0;
    fetch_err = 1'b0;
    case (r_state)
      S_REQ: begin
        ibus_req = 1'b1;
        busy     = 1'b1;
      end
      S_EXEC:  cpu_en    = 1'b1;
      S_HALT:  fetch_err = 1'b1;
      default: ;
    endcase
  end

  // Address capture at launch; held for the whole transaction.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ibus_addr <= 32'h0;
    end else if (w_launch) begin
      r_ibus_addr <= instr_addr;
    end
  end

  // Instruction latch: only an accepted acknowledge (or reset) changes it,
  // so the core sees a stable word in every cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_instr <= RESET_INSTR;
    end else if (w_bus_ack) begin
      r_instr <= ibus_rdata;
    end
  end

  // Wait-cycle counter: cleared at launch, counts unanswered REQ cycles and
  // saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt <= 16'h0;
    end else if (w_launch) begin
      r_cnt <= 16'h0;
    end else if (w_in_req && !w_bus_err && !w_bus_ack && !w_timeout &&
                 (r_cnt != LP_CNT_MAX)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign instr     = r_instr;
  assign ibus_addr = r_ibus_addr;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_nf_fetch_unit.sv
// Testbench for nf_fetch_unit: the bench plays the instruction bus slave and
// predicts each fetched word, its address and its cycle timing from the
// fetch rules (3 + wait cycles per instruction, sticky halt, reset values).
module tb_nf_fetch_unit;

  localparam int          TB_TIMEOUT  = 4;
  localparam logic [31:0] RESET_WORD  = 32'h0000_0013;

  logic        clk;
  logic        resetn;
  logic        run;
  logic [31:0] instr_addr;
  logic [31:0] instr;
  logic        cpu_en;
  logic [31:0] ibus_addr;
  logic        ibus_req;
  logic        ibus_ack;
  logic [31:0] ibus_rdata;
  logic        ibus_err;
  logic        busy;
  logic        fetch_err;
  logic [1:0]  dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_exec_cyc = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_instr;
  logic [31:0] exp_word;

  nf_fetch_unit #(
    .TIMEOUT     (TB_TIMEOUT),
    .RESET_INSTR (RESET_WORD)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .run        (run),
    .instr_addr (instr_addr),
    .instr      (instr),
    .cpu_en     (cpu_en),
    .ibus_addr  (ibus_addr),
    .ibus_req   (ibus_req),
    .ibus_ack   (ibus_ack),
    .ibus_rdata (ibus_rdata),
    .ibus_err   (ibus_err),
    .busy       (busy),
    .fetch_err  (fetch_err),
    .dbg_state  (dbg_state)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Scoreboard: every cpu_en pulse must present the next expected word.
  always @(negedge clk) begin
    if (resetn && cpu_en) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_cpu_en: instr=%h, no fetch pending", instr);
      end else begin
        exp_word = exp_q.pop_front();
        if (instr !== exp_word) begin
          n_fail++;
          $display("FAIL sb_instr: got %h want %h", instr, exp_word);
        end
      end
    end
  end

  task automatic do_reset();
    run        = 1'b0;
    ibus_ack   = 1'b0;
    ibus_err   = 1'b0;
    ibus_rdata = 32'h0;
    instr_addr = 32'h0;
    resetn     = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn    = 1'b1;
    exp_q.delete();
    exp_instr = RESET_WORD;
  endtask

  // One fetch from IDLE: launch, 'waits' unanswered REQ cycles, then ack.
  // Ends in IDLE, ready for a back-to-back launch.
  task automatic fetch_one(input logic [31:0] addr, input int waits,
                           input logic [31:0] data, input bit chained);
    instr_addr = addr;
    run        = 1'b1;
    ibus_ack   = 1'b0;
    ibus_err   = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (ibus_req !== 1'b1 || busy !== 1'b1 || cpu_en !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_launch: req=%b busy=%b en=%b want 1 1 0", ibus_req, busy, cpu_en);
    end
    n_cmp++;
    if (ibus_addr !== addr) begin
      n_fail++;
      $display("FAIL fetch_addr: got %h want %h", ibus_addr, addr);
    end
    instr_addr = $urandom;
    for (int w = 0; w < waits; w++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (ibus_req !== 1'b1 || busy !== 1'b1 || ibus_addr !== addr || instr !== exp_instr) begin
        n_fail++;
        $display("FAIL fetch_wait%0d: req=%b busy=%b addr=%h instr=%h want 1 1 %h %h",
                 w, ibus_req, busy, ibus_addr, instr, addr, exp_instr);
      end
    end
    ibus_ack   = 1'b1;
    ibus_rdata = data;
    exp_q.push_back(data);
    exp_instr  = data;
    @(posedge clk); #1;
    ibus_ack   = 1'b0;
    ibus_rdata = $urandom;
    n_cmp++;
    if (cpu_en !== 1'b1 || ibus_req !== 1'b0 || busy !== 1'b0 ||
        fetch_err !== 1'b0 || instr !== data) begin
      n_fail++;
      $display("FAIL fetch_exec: en=%b req=%b busy=%b err=%b instr=%h want 1 0 0 0 %h",
               cpu_en, ibus_req, busy, fetch_err, instr, data);
    end
    if (chained) begin
      n_cmp++;
      if (cyc - last_exec_cyc !== 3 + waits) begin
        n_fail++;
        $display("FAIL fetch_period: got %0d want %0d", cyc - last_exec_cyc, 3 + waits);
      end
    end
    last_exec_cyc = cyc;
    @(posedge clk); #1;
    n_cmp++;
    if (cpu_en !== 1'b0 || ibus_req !== 1'b0 || instr !== data) begin
      n_fail++;
      $display("FAIL fetch_after: en=%b req=%b instr=%h want 0 0 %h", cpu_en, ibus_req, instr, data);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (instr !== RESET_WORD || ibus_addr !== 32'h0 || ibus_req !== 1'b0 ||
        busy !== 1'b0 || cpu_en !== 1'b0 || fetch_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: instr=%h addr=%h req=%b busy=%b en=%b err=%b",
               instr, ibus_addr, ibus_req, busy, cpu_en, fetch_err);
    end
    // Without run the block must stay quiet.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (ibus_req !== 1'b0 || cpu_en !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle: req=%b en=%b want 0 0", ibus_req, cpu_en);
      end
    end
  endtask

  task automatic test_zero_wait();
    fetch_one(32'h0, 0, 32'h0050_0093, 1'b0);
    fetch_one(32'h4, 0, $urandom, 1'b1);
    fetch_one(32'h8, 0, $urandom, 1'b1);
  endtask

  task automatic test_wait_states();
    run = 1'b0;
    @(posedge clk); #1;
    fetch_one(32'h100, 3, $urandom, 1'b0);
    fetch_one(32'h104, 3, $urandom, 1'b1);
  endtask

  task automatic test_run_gating();
    logic [31:0] word;
    word       = $urandom;
    instr_addr = 32'h200;
    run        = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (ibus_req !== 1'b1 || ibus_addr !== 32'h200) begin
      n_fail++;
      $display("FAIL gate_hold: req=%b addr=%h want 1 00000200", ibus_req, ibus_addr);
    end
    ibus_ack   = 1'b1;
    ibus_rdata = word;
    exp_q.push_back(word);
    exp_instr  = word;
    @(posedge clk); #1;
    ibus_ack = 1'b0;
    n_cmp++;
    if (cpu_en !== 1'b1 || instr !== word) begin
      n_fail++;
      $display("FAIL gate_exec: en=%b instr=%h want 1 %h", cpu_en, instr, word);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (ibus_req !== 1'b0 || cpu_en !== 1'b0) begin
        n_fail++;
        $display("FAIL gate_parked: req=%b en=%b want 0 0", ibus_req, cpu_en);
      end
    end
    fetch_one(32'h204, 1, $urandom, 1'b0);
  endtask

  task automatic test_err_priority();
    instr_addr = 32'h300;
    run        = 1'b1;
    @(posedge clk); #1;
    ibus_err   = 1'b1;
    ibus_ack   = 1'b1;
    ibus_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    ibus_err = 1'b0;
    ibus_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (fetch_err !== 1'b1 || cpu_en !== 1'b0 || ibus_req !== 1'b0 ||
          busy !== 1'b0 || instr !== exp_instr) begin
        n_fail++;
        $display("FAIL err_halt%0d: err=%b en=%b req=%b busy=%b instr=%h want 1 0 0 0 %h",
                 i, fetch_err, cpu_en, ibus_req, busy, instr, exp_instr);
      end
      ibus_ack = 1'b1;
      @(posedge clk); #1;
      ibus_ack = 1'b0;
    end
    do_reset();
    n_cmp++;
    if (fetch_err !== 1'b0 || instr !== RESET_WORD) begin
      n_fail++;
      $display("FAIL err_cleared: err=%b instr=%h want 0 %h", fetch_err, instr, RESET_WORD);
    end
  endtask

  task automatic test_timeout();
    instr_addr = 32'h400;
    run        = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    for (int c = 1; c <= TB_TIMEOUT; c++) begin
      n_cmp++;
      if (ibus_req !== 1'b1 || fetch_err !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_req%0d: req=%b err=%b want 1 0", c, ibus_req, fetch_err);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (fetch_err !== 1'b1 || ibus_req !== 1'b0 || cpu_en !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_halt: err=%b req=%b en=%b want 1 0 0", fetch_err, ibus_req, cpu_en);
    end
    do_reset();
    // Ack in the last allowed REQ cycle is accepted.
    fetch_one(32'h404, TB_TIMEOUT - 1, $urandom, 1'b0);
    n_cmp++;
    if (fetch_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_late_ack: err=%b want 0", fetch_err);
    end
  endtask

  task automatic test_reset_mid_req();
    fetch_one(32'h500, 0, $urandom, 1'b0);
    instr_addr = 32'h504;
    run        = 1'b1;
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (ibus_req !== 1'b0 || cpu_en !== 1'b0 || instr !== RESET_WORD ||
        fetch_err !== 1'b0 || ibus_addr !== 32'h0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_req: req=%b en=%b instr=%h err=%b addr=%h busy=%b",
               ibus_req, cpu_en, instr, fetch_err, ibus_addr, busy);
    end
    resetn = 1'b1;
    run    = 1'b0;
    exp_q.delete();
    exp_instr = RESET_WORD;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [31:0] pc;
    int          gap;
    bit          chained;
    pc      = {$urandom_range(0, 32'h3FFF), 2'b00};
    chained = 1'b0;
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        run = 1'b0;
        gap = $urandom_range(1, 3);
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
          n_cmp++;
          if (ibus_req !== 1'b0 || cpu_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_gap: req=%b en=%b want 0 0", ibus_req, cpu_en);
          end
        end
        chained = 1'b0;
      end
      fetch_one(pc, $urandom_range(0, TB_TIMEOUT - 1), $urandom, chained);
      chained = 1'b1;
      pc      = pc + 32'd4;
    end
    run = 1'b0;
  endtask

  initial begin
    exp_instr  = RESET_WORD;
    resetn     = 1'b0;
    run        = 1'b0;
    instr_addr = 32'h0;
    ibus_ack   = 1'b0;
    ibus_err   = 1'b0;
    ibus_rdata = 32'h0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_run_gating();
    test_err_priority();
    test_timeout();
    test_reset_mid_req();
    test_random();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d words never executed, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
